pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, taken branches/jumps and multi-cycle data-memory accesses.
- Drives per-register enable/flush strobes.
- Keeps saturating stall/flush statistics and halts the pipe on a memory timeout.

---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, redirect and
// multi-cycle data-memory handling with saturating statistics.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       timeout_nxt;
    logic       load_use, redirect, mem_stall;

    always_comb begin
        load_use  = ex_MemRead && (ex_rt_addr != 5'd0) &&
                    ((ex_rt_addr == id_rs_addr) || (id_uses_rt && ex_rt_addr == id_rt_addr));
        redirect  = ex_branch_taken || ex_jump;
        mem_stall = mem_req && !mem_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= timeout_nxt;
            if (!pc_en && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (pc_redirect && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_nxt = mem_timeout;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                    state_nxt   = HALT;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    // Branch/load-use inputs only matter in RUN; MEM_WAIT holds EX so they are re-seen later.
    always_comb begin
        pc_en        = 1'b1;
        pc_redirect  = 1'b0;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        if (!reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                    end else if (redirect) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                    end
                end
                default: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences for
// timeout/saturation/reset corners, then random stimulus against a model.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
    localparam logic [7:0] O_RST  = 8'b0001_0101;
    localparam logic [7:0] O_NORM = 8'b1010_1010;
    localparam logic [7:0] O_LU   = 8'b0000_1110;
    localparam logic [7:0] O_BR   = 8'b1111_1110;
    localparam logic [7:0] O_FRZ  = 8'b0000_0001;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs_addr, id_rt_addr, ex_rt_addr;
    logic id_uses_rt, ex_MemRead, ex_branch_taken, ex_jump, mem_req, mem_ready;
    logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic mem_timeout;
    logic [7:0] outs;

    always #5 clk = ~clk;

    assign outs = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt_addr(ex_rt_addr),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_flush(mem_wb_flush), .stall_count(stall_count), .flush_count(flush_count),
        .mem_timeout(mem_timeout)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic       urt, mrd;
        logic [4:0] ert;
        logic       br, jmp, req, rdy;
        logic [7:0] o;
        int         st, fl, to;
    } vec_t;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    // model state
    bit m_wait, m_halt, m_to;
    int m_n, m_stall, m_flush;

    function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic urt, logic mrd,
                                logic [4:0] ert, logic br, logic jmp, logic req, logic rdy,
                                logic [7:0] o, int st, int fl, int to);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt; v.mrd = mrd; v.ert = ert;
        v.br = br; v.jmp = jmp; v.req = req; v.rdy = rdy; v.o = o; v.st = st; v.fl = fl; v.to = to;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; id_rs_addr = v.rs; id_rt_addr = v.rt; id_uses_rt = v.urt;
        ex_MemRead = v.mrd; ex_rt_addr = v.ert; ex_branch_taken = v.br; ex_jump = v.jmp;
        mem_req = v.req; mem_ready = v.rdy;
    endtask

    // drive at negedge, sample 2ns later, leave the posedge to commit state
    task automatic apply(input string nm, input vec_t v);
        drive(v);
        #2;
        chk({nm, ".outs"}, {24'd0, outs}, {24'd0, v.o});
        chk({nm, ".stall"}, 32'(stall_count), 32'(v.st));
        chk({nm, ".flush"}, 32'(flush_count), 32'(v.fl));
        chk({nm, ".timeout"}, {31'd0, mem_timeout}, 32'(v.to));
        @(negedge clk);
    endtask

    function automatic logic [7:0] model_outs();
        logic lu;
        lu = ex_MemRead && ex_rt_addr != 0 &&
             (ex_rt_addr == id_rs_addr || (id_uses_rt && ex_rt_addr == id_rt_addr));
        if (!reset)                    return O_RST;
        if (m_halt)                    return O_FRZ;
        if (m_wait)                    return mem_ready ? O_NORM : O_FRZ;
        if (mem_req && !mem_ready)     return O_FRZ;
        if (ex_branch_taken || ex_jump) return O_BR;
        if (lu)                        return O_LU;
        return O_NORM;
    endfunction

    // m_n counts the stalled cycles spent on the current access
    task automatic model_step(input logic [7:0] e);
        if (!reset) begin
            m_wait = 0; m_halt = 0; m_to = 0; m_n = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e[7]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (e[6])  m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
            if (!m_halt) begin
                if (m_wait) begin
                    if (mem_ready) m_wait = 0;
                    else begin
                        m_n++;
                        if (m_n == MAX_WAIT) begin m_halt = 1; m_to = 1; m_wait = 0; end
                    end
                end else if (mem_req && !mem_ready) begin
                    m_wait = 1; m_n = 1;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] e;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0, 0));
        @(negedge clk);

        // rst rs rt urt mrd ert br jmp req rdy | outs stall flush to
        tbl.push_back(mk(0, 5, 5, 1, 1, 5, 1, 0, 1, 0, O_RST,  0, 0, 0));
        tbl.push_back(mk(0, 3, 9, 0, 0, 2, 0, 1, 0, 1, O_RST,  0, 0, 0));
        tbl.push_back(mk(0, 7, 7, 1, 1, 7, 0, 0, 1, 1, O_RST,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 1, 5, 0, 0, 0, 0, O_LU,   0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, O_NORM, 1, 0, 0));
        tbl.push_back(mk(1, 3, 7, 0, 1, 7, 0, 0, 0, 0, O_NORM, 1, 0, 0));
        tbl.push_back(mk(1, 3, 7, 1, 1, 7, 0, 0, 0, 0, O_LU,   1, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 1, 5, 1, 0, 0, 0, O_BR,   2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,   2, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 2, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  2, 2, 0));
        tbl.push_back(mk(1, 5, 0, 0, 1, 5, 1, 0, 1, 0, O_FRZ,  3, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  4, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 5, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 5, 2, 0));
        for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

        // timeout into HALT, stall saturation while halted, reset recovery
        apply("to_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 5, 2, 0));
        for (int i = 0; i < MAX_WAIT; i++)
            apply($sformatf("to_wait%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, i, 0, 0));
        for (int i = 0; i < 14; i++)
            apply($sformatf("to_halt%0d", i), mk(1, 5, 0, 0, 1, 5, 1, 0, 1, 1, O_FRZ,
                  (MAX_WAIT + i < SAT) ? MAX_WAIT + i : SAT, 0, 1));
        apply("to_clr0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, SAT, 0, 1));
        apply("to_clr1", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0, 0));

        // reset in the middle of a memory wait
        apply("mw_a", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  0, 0, 0));
        apply("mw_b", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0, 0));
        apply("mw_r", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_RST,  2, 0, 0));
        apply("mw_c", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 0, 0, 0));

        // flush counter saturation
        for (int i = 0; i < 20; i++)
            apply($sformatf("sat%0d", i), mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR, 0,
                  (i < SAT) ? i : SAT, 0));
        apply("sat_end", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, SAT, 0));

        // randomized run against the model
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0, 0));
        model_step(O_RST);
        @(negedge clk);
        for (int c = 0; c < 1500; c++) begin
            reset           = ($urandom_range(0, 39) != 0);
            id_rs_addr      = 5'($urandom_range(0, 3));
            id_rt_addr      = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom);
            ex_MemRead      = 1'($urandom);
            ex_rt_addr      = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_jump         = ($urandom_range(0, 7) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 3) != 0);
            #2;
            e = model_outs();
            chk($sformatf("rnd%0d", c),
                {15'd0, outs, 4'(stall_count), 4'(flush_count), mem_timeout},
                {15'd0, e, 4'(m_stall), 4'(m_flush), m_to});
            model_step(e);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
